signed_or_unsigned_div: RTL and testbench
=========================================

Name: signed_or_unsigned_div

Overview:
- Sequential restoring divider. It is the inverse operation of the team's signed/unsigned multiplier.
- Computes an n-bit quotient and an n-bit remainder of a / b, one quotient bit per clock.
- A per-operation flag selects signed or unsigned semantics.
- Sits in the arithmetic/pipelining block set behind a valid/ready argument interface and a valid/ready result interface.

Parameters:
- n, 8, operand, quotient and remainder width in bits (n >= 2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- arg_vld  input  1  a, b, signed_div are valid this cycle.
- arg_rdy  output  1  divider can accept a new operation.
- a  input  n  dividend.
- b  input  n  divisor.
- signed_div  input  1  1 = two's-complement operands/results, 0 = unsigned.
- res_vld  output  1  quo and rem hold a completed result.
- res_rdy  input  1  consumer accepts the result this cycle.
- quo  output  n  quotient.
- rem  output  n  remainder.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset: state = IDLE, arg_rdy = 1, res_vld = 0, quo = 0, rem = 0, internal registers cleared. Reset asserted mid-operation aborts the operation immediately, with no result produced.
- States:
  - IDLE: arg_rdy = 1, res_vld = 0.
  - CALC: arg_rdy = 0, res_vld = 0, bit counter active.
  - DONE: arg_rdy = 0, res_vld = 1.
- Transitions:
  - IDLE -> CALC on an edge with arg_vld & arg_rdy (acceptance edge E0).
  - CALC -> DONE on the edge where the counter reaches n-1.
  - DONE -> IDLE on an edge with res_rdy.
- Capture at E0:
  - Register signed_div.
  - sign_q = signed_div & (a[n-1] ^ b[n-1]); sign_r = signed_div & a[n-1].
  - Register the magnitudes |a| and |b| (absolute value only when signed_div = 1, else raw).
  - Register flags div_by_zero (b == 0) and ovf (signed_div & a == 100..0 & b == all-ones).
  - Partial remainder cleared to 0.
- CALC (one edge per bit, MSB first):
  - Shift the (n+1)-bit partial remainder left and bring in the next dividend bit.
  - Trial subtract |b|. If the result is non-negative, keep it and set the quotient bit to 1; else restore and set the bit to 0.
  - Counter goes 0..n-1, so exactly n CALC edges (E1..En).
- Final edge En: quo/rem are registered with these overrides, in priority order:
  1. div_by_zero: quo = all-ones, rem = original a (both signed and unsigned).
  2. ovf: quo = 100..0 (most negative value), rem = 0.
  3. Otherwise: quo = sign_q ? -q_mag : q_mag; rem = sign_r ? -r_mag : r_mag.
- Signed semantics: quotient truncates toward zero; remainder takes the sign of the dividend; a == quo*b + rem always holds, except divide-by-zero.
- Latency and throughput:
  - res_vld rises after edge En, i.e. exactly n cycles after the acceptance edge. Latency is fixed and data-independent, including the special cases.
  - Minimum initiation interval is n+2 cycles: new args cannot be accepted on the same edge the result is consumed.
- Backpressure: while res_vld & !res_rdy, quo/rem/res_vld are held stable indefinitely.
- Input isolation: a, b, signed_div are ignored except at the acceptance edge; arg_vld with arg_rdy = 0 has no effect.
- Output hold: quo/rem keep their last value after the result handshake; they are only meaningful while res_vld = 1.

Decomposition:
- Package div_pkg: enum state_t {IDLE, CALC, DONE}.
- Counter width: localparam cnt_w = $clog2(n) inside the module.
- Sub-module div_step (combinational, parameter n): inputs partial remainder, next dividend bit, divisor magnitude; outputs next partial remainder and quotient bit. Instantiated once in the top FSM datapath.

Test Plan (n = 8):
- Unsigned 200 / 7 (signed_div = 0, a = 0xC8, b = 0x07) -> res_vld 8 cycles after acceptance, quo = 0x1C (28), rem = 0x04.
- Signed -7 / 2 (a = 0xF9, b = 0x02, signed_div = 1) -> quo = 0xFD (-3), rem = 0xFF (-1). Same operands with signed_div = 0 -> quo = 0x7C (124), rem = 0x01.
- Divide by zero: a = 0x25, b = 0x00, either mode -> quo = 0xFF, rem = 0x25, with the same 8-cycle latency.
- Signed overflow: a = 0x80, b = 0xFF, signed_div = 1 -> quo = 0x80, rem = 0x00. Signed 7 / -3 (0x07, 0xFD) -> quo = 0xFE, rem = 0x01.
- Backpressure/handshake:
  - Hold res_rdy = 0 for 5 cycles after res_vld -> quo/rem stable and arg_rdy = 0 throughout.
  - Changing a/b during CALC does not alter the result.
  - Back-to-back ops with arg_vld held high -> accepts every n+2 cycles.
- Reset mid-operation: assert rst at CALC cycle 4 -> arg_rdy = 1, res_vld = 0, quo = rem = 0 immediately. The next operation 100 / 9 gives quo = 11, rem = 1.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types for the sequential restoring divider.
package div_pkg;

    // Controller states: waiting for arguments, iterating, holding a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Per-operation flags captured at acceptance and consumed on the final edge.
    typedef struct packed {
        logic sign_q;       // quotient must be negated
        logic sign_r;       // remainder must be negated (follows dividend sign)
        logic div_by_zero;  // divisor was zero
        logic ovf;          // most-negative / -1 in signed mode
    } op_flags_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial subtract
// the divisor magnitude, keep the difference or restore.
module div_step #(
    parameter int n = 8
) (
    input  logic [n-1:0] rem_in,
    input  logic         dvd_bit,
    input  logic [n-1:0] dvs_mag,
    output logic [n-1:0] rem_out,
    output logic         q_bit
);

    logic [n:0]   shifted;
    logic [n-1:0] trial;

    // Partial remainder is always below the divisor, so after the shift it
    // needs n+1 bits, and a successful subtraction fits back into n bits.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        rem_out = '0;
        q_bit   = 1'b0;
        shifted = {rem_in, dvd_bit};
        trial   = shifted[n-1:0] - dvs_mag;
        if (shifted >= {1'b0, dvs_mag}) begin
            rem_out = trial;
            q_bit   = 1'b1;
        end else begin
            rem_out = shifted[n-1:0];
            q_bit   = 1'b0;
        end
    end

endmodule

// File: rtl/signed_or_unsigned_div.sv
// Sequential restoring divider: n-bit quotient and remainder, one quotient
// bit per clock, signed or unsigned per operation, valid/ready on both sides.
module signed_or_unsigned_div
    import div_pkg::*;
#(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         arg_vld,
    output logic         arg_rdy,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         signed_div,
    output logic         res_vld,
    input  logic         res_rdy,
    output logic [n-1:0] quo,
    output logic [n-1:0] rem
);

    localparam int cnt_w = $clog2(n);
    localparam logic [cnt_w-1:0] last_cnt = cnt_w'(n - 1);
    localparam logic [n-1:0] most_neg = {1'b1, {(n-1){1'b0}}};

    state_t          state, state_nxt;
    logic [cnt_w-1:0] cnt;
    logic            signed_q;
    op_flags_t       flags;
    logic [n-1:0]    a_orig;    // raw dividend, returned as rem on divide-by-zero
    logic [n-1:0]    dvd;       // dividend magnitude, shifted out MSB first; quotient shifts in
    logic [n-1:0]    dvs_mag;   // divisor magnitude
    logic [n-1:0]    pr;        // partial remainder

    logic         accept;
    logic         last_step;
    logic [n-1:0] a_mag, b_mag;
    logic [n-1:0] pr_nxt;
    logic         q_bit;
    logic [n-1:0] q_mag;
    op_flags_t    flags_in;

    assign accept    = arg_vld & arg_rdy;
    assign last_step = (state == CALC) && (cnt == last_cnt);

    // Magnitudes and flags derived from the incoming operands at acceptance.
    always_comb begin
        a_mag                = (signed_div & a[n-1]) ? (~a + 1'b1) : a;
        b_mag                = (signed_div & b[n-1]) ? (~b + 1'b1) : b;
        flags_in.sign_q      = signed_div & (a[n-1] ^ b[n-1]);
        flags_in.sign_r      = signed_div & a[n-1];
        flags_in.div_by_zero = (b == '0);
        flags_in.ovf         = signed_div & (a == most_neg) & (b == '1);
    end

    div_step #(.n(n)) u_step (
        .rem_in  (pr),
        .dvd_bit (dvd[n-1]),
        .dvs_mag (dvs_mag),
        .rem_out (pr_nxt),
        .q_bit   (q_bit)
    );

    // Quotient magnitude once the final bit is known.
    assign q_mag = {dvd[n-2:0], q_bit};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nxt = state;
        arg_rdy   = 1'b0;
        res_vld   = 1'b0;
        case (state)
            IDLE: begin
                arg_rdy = 1'b1;
                if (arg_vld) state_nxt = CALC;
            end
            CALC: begin
                if (cnt == last_cnt) state_nxt = DONE;
            end
            DONE: begin
                res_vld = 1'b1;
                if (res_rdy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, per-bit iteration and result registration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            signed_q <= 1'b0;
            flags    <= '0;
            a_orig   <= '0;
            dvd      <= '0;
            dvs_mag  <= '0;
            pr       <= '0;
            quo      <= '0;
            rem      <= '0;
        end else if (accept) begin
            cnt      <= '0;
            signed_q <= signed_div;
            flags    <= flags_in;
            a_orig   <= a;
            dvd      <= a_mag;
            dvs_mag  <= b_mag;
            pr       <= '0;
        end else if (state == CALC) begin
            cnt <= cnt + 1'b1;
            pr  <= pr_nxt;
            dvd <= q_mag;
            if (last_step) begin
                if (flags.div_by_zero) begin
                    quo <= '1;
                    rem <= a_orig;
                end else if (flags.ovf) begin
                    quo <= most_neg;
                    rem <= '0;
                end else begin
                    quo <= (signed_q & flags.sign_q) ? (~q_mag + 1'b1) : q_mag;
                    rem <= (signed_q & flags.sign_r) ? (~pr_nxt + 1'b1) : pr_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_signed_or_unsigned_div.sv
// Self-checking bench for signed_or_unsigned_div (n = 8).
module tb_signed_or_unsigned_div;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         arg_vld = 1'b0;
    logic         arg_rdy;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         signed_div = 1'b0;
    logic         res_vld;
    logic         res_rdy = 1'b0;
    logic [N-1:0] quo;
    logic [N-1:0] rem;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   acc_log[$];
    bit   seen = 1'b0;

    signed_or_unsigned_div #(.n(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .arg_vld    (arg_vld),
        .arg_rdy    (arg_rdy),
        .a          (a),
        .b          (b),
        .signed_div (signed_div),
        .res_vld    (res_vld),
        .res_rdy    (res_rdy),
        .quo        (quo),
        .rem        (rem)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference division from plain integer arithmetic.
    function automatic logic [2*N-1:0] model(input logic [N-1:0] x, input logic [N-1:0] y, input bit s);
        int sx, sy, q, r;
        if (y == 0) return {{N{1'b1}}, x};
        if (s) begin
            sx = $signed(x);
            sy = $signed(y);
            if (sx == -(1 << (N-1)) && sy == -1) return {1'b1, {(2*N-1){1'b0}}};
            q = sx / sy;
            r = sx % sy;
        end else begin
            q = int'(x) / int'(y);
            r = int'(x) % int'(y);
        end
        return {q[N-1:0], r[N-1:0]};
    endfunction

    // Scoreboard: predicts at acceptance, checks every cycle a result is shown.
    always @(negedge clk) begin
        logic [2*N-1:0] m;
        if (rst) begin
            sb.delete();
            seen = 1'b0;
        end else begin
            if (res_vld) begin
                if (sb.size() == 0) begin
                    check("res_expected", 32'(sb.size()), 32'd1);
                end else begin
                    if (!seen) begin
                        check("latency", 32'(cyc - sb[0].acc), 32'(N));
                        seen = 1'b1;
                    end
                    check("mdl_quo", 32'(quo), 32'(sb[0].q));
                    check("mdl_rem", 32'(rem), 32'(sb[0].r));
                    check("rdy_low_in_done", 32'(arg_rdy), 32'd0);
                    if (res_rdy) begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end
            if (arg_vld && arg_rdy) begin
                m = model(a, b, signed_div);
                sb.push_back('{q: m[2*N-1:N], r: m[N-1:0], acc: cyc + 1});
                acc_log.push_back(cyc + 1);
            end
        end
    end

    // One operation with literal expectations, input scrambling during CALC
    // and optional result backpressure.
    task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input bit ts,
                         input logic [N-1:0] eq, input logic [N-1:0] er, input int hold);
        a = ta; b = tb; signed_div = ts; arg_vld = 1'b1;
        @(posedge clk); #1;
        a = ~ta; b = ~tb; signed_div = ~ts;
        repeat (3) begin @(posedge clk); #1; end
        arg_vld = 1'b0;
        for (int k = 0; k < 3*N && !res_vld; k++) begin @(posedge clk); #1; end
        if (!res_vld) begin
            check("res_timeout", 32'd0, 32'd1);
            return;
        end
        check("lit_quo", 32'(quo), 32'(eq));
        check("lit_rem", 32'(rem), 32'(er));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("bp_vld", 32'(res_vld), 32'd1);
            check("bp_rdy", 32'(arg_rdy), 32'd0);
            check("bp_quo", 32'(quo), 32'(eq));
            check("bp_rem", 32'(rem), 32'(er));
        end
        res_rdy = 1'b1;
        @(posedge clk); #1;
        res_rdy = 1'b0;
        check("vld_after_hs", 32'(res_vld), 32'd0);
        check("rdy_after_hs", 32'(arg_rdy), 32'd1);
    endtask

    initial begin
        #1;
        check("rst_arg_rdy", 32'(arg_rdy), 32'd1);
        check("rst_res_vld", 32'(res_vld), 32'd0);
        check("rst_quo", 32'(quo), 32'd0);
        check("rst_rem", 32'(rem), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        do_op(8'hC8, 8'h07, 1'b0, 8'h1C, 8'h04, 0);
        do_op(8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 0);
        do_op(8'hF9, 8'h02, 1'b0, 8'h7C, 8'h01, 0);
        do_op(8'h25, 8'h00, 1'b0, 8'hFF, 8'h25, 0);
        do_op(8'h25, 8'h00, 1'b1, 8'hFF, 8'h25, 0);
        do_op(8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 0);
        do_op(8'h07, 8'hFD, 1'b1, 8'hFE, 8'h01, 5);
        do_op(8'h80, 8'h01, 1'b1, 8'h80, 8'h00, 0);
        do_op(8'h81, 8'h07, 1'b1, 8'hEE, 8'hFF, 0);
        do_op(8'hFF, 8'hFF, 1'b0, 8'h01, 8'h00, 0);

        // Reset during CALC aborts the operation at once.
        a = 8'hC8; b = 8'h07; signed_div = 1'b0; arg_vld = 1'b1;
        @(posedge clk); #1;
        arg_vld = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_arg_rdy", 32'(arg_rdy), 32'd1);
        check("abort_res_vld", 32'(res_vld), 32'd0);
        check("abort_quo", 32'(quo), 32'd0);
        check("abort_rem", 32'(rem), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (N + 2) begin @(posedge clk); #1; end
        check("abort_no_result", 32'(res_vld), 32'd0);
        do_op(8'd100, 8'd9, 1'b0, 8'd11, 8'd1, 0);

        // Back-to-back with arg_vld and res_rdy held high.
        acc_log.delete();
        a = 8'd100; b = 8'd9; signed_div = 1'b0;
        res_rdy = 1'b1; arg_vld = 1'b1;
        repeat (3*(N+2) + 2) @(posedge clk);
        #1 arg_vld = 1'b0;
        repeat (2*N + 4) @(posedge clk);
        #1 res_rdy = 1'b0;
        check("b2b_count", 32'(acc_log.size()), 32'd4);
        for (int i = 1; i < acc_log.size(); i++)
            check("b2b_interval", 32'(acc_log[i] - acc_log[i-1]), 32'(N + 2));
        check("b2b_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
